// File: rtl/mmio_decoder.sv
// Memory-mapped I/O decoder: splits CPU accesses between data memory and a small
// register file of switches, debounced buttons, LEDs, display and button interrupts.
module mmio_decoder #(
  parameter int IO_SEL_BIT      = 7,
  parameter int NUM_BTN         = 2,
  parameter int SW_W            = 16,
  parameter int LED_W           = 12,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic [31:0]        addr,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               mem_we,
  input  logic [31:0]        mem_rdata,
  input  logic [NUM_BTN-1:0] btn,
  input  logic [SW_W-1:0]    sw,
  output logic [LED_W-1:0]   led,
  output logic [31:0]        disp_value,
  output logic               disp_en,
  output logic               irq
);

  // The counter only has to hold 0..DEBOUNCE_CYCLES-1; the final count is acted on, never stored.
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    REG_STATUS  = 3'd0,
    REG_SWITCH  = 3'd1,
    REG_LED     = 3'd2,
    REG_DISP    = 3'd3,
    REG_BTNLVL  = 3'd4,
    REG_IRQMASK = 3'd5,
    REG_RSVD6   = 3'd6,
    REG_RSVD7   = 3'd7
  } io_reg_e;

  localparam int DISP_EN_BIT = 16;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic    io_sel;
  logic    io_we;
  io_reg_e reg_sel;

  assign io_sel  = addr[IO_SEL_BIT];
  assign io_we   = we & io_sel;
  assign mem_we  = we & ~io_sel;
  assign reg_sel = io_reg_e'(addr[4:2]);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [SW_W-1:0]               sw_meta, sw_sync;
  logic [NUM_BTN-1:0]            btn_meta, btn_sync;
  logic [NUM_BTN-1:0]            btn_acc, btn_acc_d;
  logic [NUM_BTN-1:0][CNT_W-1:0] cnt, cnt_d;
  logic [NUM_BTN-1:0]            btn_rise;
  logic [NUM_BTN-1:0]            status, status_d, status_clr;
  logic [NUM_BTN-1:0]            irq_mask;
  logic [LED_W-1:0]              led_q;
  logic [31:0]                   disp_q;
  logic                          disp_en_q;
  logic                          irq_q;

  // ---------------------------------------------------------------------------
  // Debounce: count consecutive cycles of disagreement, accept on the last one
  // ---------------------------------------------------------------------------
  // NOTE: every output of a combinational block is given a default first so that
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    btn_acc_d = btn_acc;
    cnt_d     = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (btn_sync[i] != btn_acc[i]) begin
        if (cnt[i] == CNT_LAST) begin
          btn_acc_d[i] = btn_sync[i];
        end else begin
          cnt_d[i] = cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign btn_rise = btn_acc_d & ~btn_acc;

  // A rising acceptance wins over a simultaneous write-one-to-clear.
  always_comb begin
    status_clr = '0;
    if (io_we && reg_sel == REG_STATUS) begin
      status_clr = wdata[NUM_BTN-1:0];
    end
    status_d = (status & ~status_clr) | btn_rise;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      sw_meta   <= '0;
      sw_sync   <= '0;
      btn_meta  <= '0;
      btn_sync  <= '0;
      btn_acc   <= '0;
      cnt       <= '0;
      status    <= '0;
      irq_mask  <= '0;
      led_q     <= '0;
      disp_q    <= '0;
      disp_en_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      sw_meta  <= sw;
      sw_sync  <= sw_meta;
      btn_meta <= btn;
      btn_sync <= btn_meta;
      btn_acc  <= btn_acc_d;
      cnt      <= cnt_d;
      status   <= status_d;
      irq_q    <= |(status & irq_mask);

      if (io_we) begin
        case (reg_sel)
          REG_LED: led_q <= wdata[LED_W-1:0];
          REG_DISP: begin
            disp_q    <= wdata;
            disp_en_q <= 1'b1;
          end
          REG_IRQMASK: begin
            irq_mask  <= wdata[NUM_BTN-1:0];
            disp_en_q <= wdata[DISP_EN_BIT];
          end
          default: ;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  logic [31:0] io_rdata;

  always_comb begin
    io_rdata = '0;
    case (reg_sel)
      REG_STATUS:  io_rdata = 32'(status);
      REG_SWITCH:  io_rdata = 32'(sw_sync);
      REG_LED:     io_rdata = 32'(led_q);
      REG_DISP:    io_rdata = disp_q;
      REG_BTNLVL:  io_rdata = 32'(btn_acc);
      REG_IRQMASK: begin
        io_rdata              = 32'(irq_mask);
        io_rdata[DISP_EN_BIT] = disp_en_q;
      end
      default:     io_rdata = '0;
    endcase
  end

  assign rdata      = io_sel ? io_rdata : mem_rdata;
  assign led        = led_q;
  assign disp_value = disp_q;
  assign disp_en    = disp_en_q;
  assign irq        = irq_q;

  // Upper address and data bits are intentionally not decoded.
  logic unused_bits;
  assign unused_bits = ^{addr, wdata};

endmodule

// File: tb/tb_mmio_decoder.sv
// Bench for mmio_decoder: constant-table vectors, directed debounce/W1C/reset
// sequences, then random traffic checked against a behavioural model.
module tb_mmio_decoder;

  localparam int DC = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        mem_we;
  logic [31:0] mem_rdata = '0;
  logic [1:0]  btn = '0;
  logic [15:0] sw = '0;
  logic [11:0] led;
  logic [31:0] disp_value;
  logic        disp_en;
  logic        irq;

  int checks = 0;
  int errors = 0;

  mmio_decoder #(
    .IO_SEL_BIT(7), .NUM_BTN(2), .SW_W(16), .LED_W(12), .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk(clk), .reset(reset), .we(we), .addr(addr), .wdata(wdata), .rdata(rdata),
    .mem_we(mem_we), .mem_rdata(mem_rdata), .btn(btn), .sw(sw), .led(led),
    .disp_value(disp_value), .disp_en(disp_en), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Behavioural model: a button level is accepted once the last DC synchronised
  // samples all disagree with the current accepted level.
  // ---------------------------------------------------------------------------
  logic [1:0]  m_bq[$];
  logic [15:0] m_swq[$];
  logic [1:0]  m_hist[$];
  logic [1:0]  m_acc, m_status, m_mask;
  logic [11:0] m_led;
  logic [31:0] m_disp;
  logic        m_en, m_irq;

  task automatic model_step();
    logic [1:0] s, acc_n, rose, clr;
    logic       irq_n, all_diff;
    if (reset) begin
      m_bq = '{2'b00, 2'b00};
      m_swq = '{16'h0, 16'h0};
      m_hist.delete();
      m_acc = '0; m_status = '0; m_mask = '0;
      m_led = '0; m_disp = '0; m_en = 1'b0; m_irq = 1'b0;
      return;
    end
    s = m_bq.pop_front();
    m_bq.push_back(btn);
    void'(m_swq.pop_front());
    m_swq.push_back(sw);
    m_hist.push_back(s);
    if (m_hist.size() > DC) void'(m_hist.pop_front());
    acc_n = m_acc;
    for (int i = 0; i < 2; i++) begin
      if (m_hist.size() == DC) begin
        all_diff = 1'b1;
        foreach (m_hist[k]) if (m_hist[k][i] == m_acc[i]) all_diff = 1'b0;
        if (all_diff) acc_n[i] = ~m_acc[i];
      end
    end
    rose  = acc_n & ~m_acc;
    irq_n = |(m_status & m_mask);
    clr   = (we && addr[7] && addr[4:2] == 3'd0) ? wdata[1:0] : 2'b00;
    m_status = (m_status & ~clr) | rose;
    if (we && addr[7]) begin
      case (addr[4:2])
        3'd2: m_led = wdata[11:0];
        3'd3: begin m_disp = wdata; m_en = 1'b1; end
        3'd5: begin m_mask = wdata[1:0]; m_en = wdata[16]; end
        default: ;
      endcase
    end
    m_acc = acc_n;
    m_irq = irq_n;
  endtask

  function automatic logic [31:0] model_rdata(logic [31:0] a, logic [31:0] mrd);
    if (!a[7]) return mrd;
    case (a[4:2])
      3'd0: return {30'd0, m_status};
      3'd1: return {16'd0, m_swq[0]};
      3'd2: return {20'd0, m_led};
      3'd3: return m_disp;
      3'd4: return {30'd0, m_acc};
      3'd5: return {15'd0, m_en, 14'd0, m_mask};
      default: return 32'd0;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wdata = d;
    tick();
    we = 1'b0;
  endtask

  task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
    we = 1'b0; addr = a;
    #1;
    check(name, rdata, exp);
  endtask

  task automatic do_reset();
    reset = 1'b1; we = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic check_all(input string tag);
    check({tag, "_rdata"}, rdata, model_rdata(addr, mem_rdata));
    check({tag, "_mem_we"}, {31'd0, mem_we}, {31'd0, we & ~addr[7]});
    check({tag, "_led"}, {20'd0, led}, {20'd0, m_led});
    check({tag, "_disp"}, disp_value, m_disp);
    check({tag, "_disp_en"}, {31'd0, disp_en}, {31'd0, m_en});
    check({tag, "_irq"}, {31'd0, irq}, {31'd0, m_irq});
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mrd;
    logic [31:0] exp_rdata;
    logic        exp_mem_we;
    logic [11:0] exp_led;
    logic [31:0] exp_disp;
    logic        exp_en;
  } vec_t;

  vec_t tbl[13];

  initial begin
    tbl[0]  = '{1'b1, 32'h40, 32'hDEADBEEF, 32'h11112222, 32'h11112222, 1'b1, 12'h000, 32'h0, 1'b0};
    tbl[1]  = '{1'b1, 32'h84, 32'h0000FFFF, 32'h0,        32'h0,        1'b0, 12'h000, 32'h0, 1'b0};
    tbl[2]  = '{1'b0, 32'h40, 32'h0,        32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 12'h000, 32'h0, 1'b0};
    tbl[3]  = '{1'b1, 32'h88, 32'hFFFFFFFF, 32'h0,        32'h00000FFF, 1'b0, 12'hFFF, 32'h0, 1'b0};
    tbl[4]  = '{1'b0, 32'h88, 32'h0,        32'h55555555, 32'h00000FFF, 1'b0, 12'hFFF, 32'h0, 1'b0};
    tbl[5]  = '{1'b1, 32'h8C, 32'h1234,     32'h0,        32'h00001234, 1'b0, 12'hFFF, 32'h1234, 1'b1};
    tbl[6]  = '{1'b0, 32'h94, 32'h0,        32'h0,        32'h00010000, 1'b0, 12'hFFF, 32'h1234, 1'b1};
    tbl[7]  = '{1'b1, 32'h94, 32'h3,        32'h0,        32'h00000003, 1'b0, 12'hFFF, 32'h1234, 1'b0};
    tbl[8]  = '{1'b1, 32'h98, 32'hFFFFFFFF, 32'h0,        32'h0,        1'b0, 12'hFFF, 32'h1234, 1'b0};
    tbl[9]  = '{1'b0, 32'h9C, 32'h0,        32'h0,        32'h0,        1'b0, 12'hFFF, 32'h1234, 1'b0};
    tbl[10] = '{1'b1, 32'h90, 32'hFFFF,     32'h0,        32'h0,        1'b0, 12'hFFF, 32'h1234, 1'b0};
    tbl[11] = '{1'b1, 32'h94, 32'h00010001, 32'h0,        32'h00010001, 1'b0, 12'hFFF, 32'h1234, 1'b1};
    tbl[12] = '{1'b1, 32'h08, 32'h0,        32'h77777777, 32'h77777777, 1'b1, 12'hFFF, 32'h1234, 1'b1};

    @(negedge clk);

    // Reset state: outputs and every I/O register read zero.
    do_reset();
    check("rst_led", {20'd0, led}, 32'd0);
    check("rst_disp", disp_value, 32'd0);
    check("rst_en_irq", {30'd0, disp_en, irq}, 32'd0);
    for (int r = 0; r < 8; r++) rd($sformatf("rst_reg%0d", r), 32'h80 + 32'(r * 4), 32'd0);

    // Table-driven register and memory-path vectors.
    for (int i = 0; i < 13; i++) begin
      we = tbl[i].we; addr = tbl[i].addr; wdata = tbl[i].wdata; mem_rdata = tbl[i].mrd;
      tick();
      check($sformatf("tbl%0d_rdata", i), rdata, tbl[i].exp_rdata);
      check($sformatf("tbl%0d_mem_we", i), {31'd0, mem_we}, {31'd0, tbl[i].exp_mem_we});
      check($sformatf("tbl%0d_led", i), {20'd0, led}, {20'd0, tbl[i].exp_led});
      check($sformatf("tbl%0d_disp", i), disp_value, tbl[i].exp_disp);
      check($sformatf("tbl%0d_en", i), {31'd0, disp_en}, {31'd0, tbl[i].exp_en});
    end
    we = 1'b0;

    // Debounce: held press accepted on edge 6, short pulse ignored.
    do_reset();
    btn = 2'b01;
    for (int e = 1; e <= 6; e++) begin
      tick();
      rd($sformatf("db_status_edge%0d", e), 32'h80, (e >= 6) ? 32'h1 : 32'h0);
    end
    rd("db_btnlvl", 32'h90, 32'h1);
    btn = 2'b00;
    repeat (8) tick();
    rd("db_release_lvl", 32'h90, 32'h0);
    rd("db_release_status", 32'h80, 32'h1);
    wr(32'h80, 32'h1);
    rd("db_cleared", 32'h80, 32'h0);
    btn = 2'b01;
    repeat (DC - 1) tick();
    btn = 2'b00;
    repeat (10) tick();
    rd("db_pulse_status", 32'h80, 32'h0);
    rd("db_pulse_lvl", 32'h90, 32'h0);

    // W1C and interrupt timing.
    do_reset();
    btn = 2'b11;
    repeat (8) tick();
    rd("w1c_status3", 32'h80, 32'h3);
    wr(32'h94, 32'h1);
    check("irq_mask_lag", {31'd0, irq}, 32'd0);
    tick();
    check("irq_set", {31'd0, irq}, 32'd1);
    wr(32'h80, 32'h1);
    rd("w1c_status2", 32'h80, 32'h2);
    check("irq_lag", {31'd0, irq}, 32'd1);
    tick();
    check("irq_clear", {31'd0, irq}, 32'd0);
    btn = 2'b00;
    repeat (8) tick();
    rd("fall_no_status", 32'h80, 32'h2);
    wr(32'h80, 32'h2);
    rd("w1c_bit1", 32'h80, 32'h0);
    btn = 2'b10;
    repeat (5) tick();
    rd("pre_accept", 32'h80, 32'h0);
    wr(32'h80, 32'h2);
    rd("set_beats_clear", 32'h80, 32'h2);

    // Switch synchroniser latency.
    sw = 16'hA5A5;
    tick();
    rd("sw_edge1", 32'h84, 32'h0);
    tick();
    rd("sw_edge2", 32'h84, 32'h0000A5A5);

    // Reset overrides a concurrent write with everything populated.
    wr(32'h88, 32'hFFF);
    wr(32'h8C, 32'hABCD0123);
    btn = 2'b11;
    repeat (8) tick();
    rd("pre_rst_status", 32'h80, 32'h3);
    reset = 1'b1; we = 1'b1; addr = 32'h88; wdata = 32'h5; btn = 2'b00;
    tick();
    check("rst2_led", {20'd0, led}, 32'd0);
    check("rst2_disp", disp_value, 32'd0);
    check("rst2_en_irq", {30'd0, disp_en, irq}, 32'd0);
    for (int r = 0; r < 8; r++) rd($sformatf("rst2_reg%0d", r), 32'h80 + 32'(r * 4), 32'd0);
    reset = 1'b0;

    // Reset mid-debounce discards the partial count.
    repeat (4) tick();
    btn = 2'b01;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      tick();
      rd($sformatf("mid_rst_edge%0d", e), 32'h80, (e >= 6) ? 32'h1 : 32'h0);
    end

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      reset     = ($urandom_range(0, 255) == 0);
      we        = $urandom_range(0, 1) == 1;
      addr      = $urandom();
      wdata     = $urandom();
      mem_rdata = $urandom();
      if ($urandom_range(0, 7) == 0) btn[$urandom_range(0, 1)] ^= 1'b1;
      if ($urandom_range(0, 15) == 0) sw = 16'($urandom());
      tick();
      check_all($sformatf("rnd%0d", c));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmio_decoder.md
MMIO_DECODER -- requirements
Module: mmio_decoder

Interface
REQ-001 SHALL have parameter IO_SEL_BIT, default 7, meaning address bit that selects I/O (1) versus data memory (0).
REQ-002 SHALL have parameter NUM_BTN, default 2, meaning number of push-button channels (1..16).
REQ-003 SHALL have parameter SW_W, default 16, meaning switch bank width (1..32).
REQ-004 SHALL have parameter LED_W, default 12, meaning LED register width (1..32).
REQ-005 SHALL have parameter DEBOUNCE_CYCLES, default 16, meaning consecutive stable cycles before a button level is accepted (>=2).
REQ-006 SHALL have clock and reset: clk input 1, single clock; reset input 1, synchronous active-high.
REQ-007 SHALL have ports: we input 1, CPU write enable; addr input 32, CPU byte address; wdata input 32, CPU write data; rdata output 32, CPU read data.
REQ-008 SHALL have ports: mem_we output 1, data-memory write enable; mem_rdata input 32, data-memory read data.
REQ-009 SHALL have ports: btn input NUM_BTN, raw asynchronous buttons; sw input SW_W, raw asynchronous switches.
REQ-010 SHALL have ports: led output LED_W; disp_value output 32, seven-segment value; disp_en output 1, display enable; irq output 1, button interrupt.

Function
REQ-011 SHALL drive mem_we = we & ~addr[IO_SEL_BIT], combinational; I/O writes never reach memory.
REQ-012 SHALL drive rdata = mem_rdata when addr[IO_SEL_BIT]=0, else the I/O register selected by addr[4:2], combinational, zero added latency.
REQ-013 SHALL decode the I/O map by addr[4:2]: 0 STATUS (W1C), 1 SWITCH (RO), 2 LED (RW), 3 DISP (RW), 4 BTNLVL (RO), 5 IRQMASK (RW), 6-7 reserved (read 0, writes ignored).
REQ-014 SHALL accept an I/O register write on the rising clk edge where we=1 and addr[IO_SEL_BIT]=1; writes to RO registers are ignored.
REQ-015 SHALL zero-extend every register narrower than 32 bits on read; writes take the low bits of wdata.
REQ-016 SHALL pass each sw bit through a 2-flop synchroniser; SWITCH reads the second-stage flops.
REQ-017 SHALL pass each btn bit through a 2-flop synchroniser followed by a per-channel debouncer: counter counts cycles where synchronised level differs from accepted level, clears when they match, and on reaching DEBOUNCE_CYCLES updates the accepted level and clears.
REQ-018 SHALL expose accepted levels in BTNLVL[NUM_BTN-1:0].
REQ-019 SHALL set STATUS bit i on the same edge that accepted level i goes 0->1; falling transitions do not affect STATUS.
REQ-020 SHALL clear STATUS bit i on a STATUS write with wdata[i]=1; wdata[i]=0 leaves bit i unchanged.
REQ-021 SHALL give set priority over clear when a rising acceptance and W1C of the same bit occur on one edge (bit stays 1).
REQ-022 SHALL latch DISP[31:0] to disp_value; DISP write also sets disp_en=1; IRQMASK bit 16 written 0 or 1 sets disp_en directly (IRQMASK bit 16 reads disp_en).
REQ-023 SHALL drive irq = |(STATUS & IRQMASK[NUM_BTN-1:0]), registered (one cycle after STATUS/IRQMASK update).
REQ-024 SHALL ignore a button pulse shorter than DEBOUNCE_CYCLES synchronised cycles (no STATUS change).

Reset
REQ-025 SHALL, on clk edge with reset=1, clear led, disp_value, disp_en, irq, STATUS, IRQMASK, accepted levels, debounce counters and synchroniser flops to 0; reset overrides any concurrent write.
REQ-026 SHALL, with reset asserted mid-debounce, discard partial counts; no STATUS set results from a press begun before reset release unless it is again held DEBOUNCE_CYCLES cycles.

Verification
REQ-027 SHALL cover memory path: we=1, addr=0x40, wdata=0xDEADBEEF -> mem_we=1; addr=0x84 with we=1 -> mem_we=0; addr=0x40 read -> rdata=mem_rdata.
REQ-028 SHALL cover LED/DISP: write 0xFFFFFFFF to addr 0x88 -> led=0xFFF, read 0x88 -> 0x00000FFF; write 0x1234 to 0x8C -> disp_value=0x1234, disp_en=1.
REQ-029 SHALL cover debounce (DEBOUNCE_CYCLES=4): btn[0] held high from before edge 1 -> STATUS reads 0x1 after edge 6, not before; 3-cycle pulse -> STATUS stays 0.
REQ-030 SHALL cover W1C/irq: STATUS=0x3, IRQMASK=0x1 -> irq=1; write 0x1 to 0x80 -> STATUS=0x2, irq=0 next cycle; W1C coinciding with new press of bit 1 -> bit 1 stays 1.
REQ-031 SHALL cover switches/reset: sw=0xA5A5 -> SWITCH reads 0xA5A5 after 2 edges; assert reset with led=0xFFF, STATUS=0x3 -> all outputs and reads 0 next edge.
